// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks an 8-entry register file. It emits the registers that the
// start mask selects, one at a time, in ascending index order, over a valid/ready stream.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset      synchronous, active-low reset
//   start      dump request, only sampled while idle
//   mask       one bit per register to dump, sampled with start
//   rf_addr    register file read address (combinational)
//   rf_data    register file read data for rf_addr, same cycle
//   out_valid  current entry is valid
//   out_ready  consumer accepts the entry
//   out_addr   register index of the current entry
//   out_data   captured register contents
//   out_last   current entry is the final one of the dump
//   busy       a dump is in progress
//   done       one-cycle pulse when a dump completes
module reg_dump_reader #(
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    mask,
   output logic [2:0]    rf_addr,
   input  logic [DW-1:0] rf_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2:0]    out_addr,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

   state_e     state_q;
   logic [7:0] pm_q;
   logic [2:0] low_idx;
   logic       pm_one_hot;
   logic [7:0] pm_rest;

   // Lowest set bit of the pending mask; scanning downwards lets the lowest one win.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pm_q[i]) begin
            low_idx = 3'(i);
         end
      end
   end

   assign pm_one_hot = (pm_q != 8'd0) && ((pm_q & (pm_q - 8'd1)) == 8'd0);

   // Pending mask once the entry in HOLD is accepted; out_addr is the selected bit.
   assign pm_rest = pm_q & ~(8'd1 << out_addr);

   assign rf_addr = (state_q == StRead) ? low_idx : 3'd0;
   assign busy    = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         pm_q      <= 8'd0;
         out_valid <= 1'b0;
         out_addr  <= 3'd0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  pm_q <= mask;
                  // An empty request completes immediately without entering READ.
                  if (mask != 8'd0) begin
                     state_q <= StRead;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            StRead: begin
               out_data  <= rf_data;
               out_addr  <= rf_addr;
               out_last  <= pm_one_hot;
               out_valid <= 1'b1;
               state_q   <= StHold;
            end
            StHold: begin
               if (out_ready) begin
                  pm_q      <= pm_rest;
                  out_valid <= 1'b0;
                  if (pm_rest == 8'd0) begin
                     state_q <= StIdle;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StRead;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter DW, default 16, register data width in bits.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a dump; sampled only while busy=0.
REQ-005 mask  input  8  bit i=1 selects register i for dump; sampled with start.
REQ-006 rf_addr  output  3  read address to the 8-entry register file.
REQ-007 rf_data  input  DW  combinational read data for rf_addr, same cycle.
REQ-008 out_valid  output  1  out_addr/out_data/out_last hold a valid entry.
REQ-009 out_ready  input  1  consumer accepts the entry when out_valid=1 and out_ready=1.
REQ-010 out_addr  output  3  register index of the current entry.
REQ-011 out_data  output  DW  register contents captured for the current entry.
REQ-012 out_last  output  1  1 when the current entry is the final one of the dump.
REQ-013 busy  output  1  1 from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-015 The block SHALL implement states IDLE, READ and HOLD, with a pending-mask register pm[7:0].
REQ-016 IDLE: busy=0, out_valid=0, rf_addr=0; start=1 loads pm<=mask; a nonzero mask goes to READ, while mask=0 stays in IDLE and pulses done next cycle.
REQ-017 READ: busy=1; rf_addr SHALL equal the lowest set bit index of pm.
REQ-018 On the READ clock edge, out_data<=rf_data, out_addr<=rf_addr, out_last<=(pm has exactly one bit set), out_valid<=1, and the state goes to HOLD.
REQ-019 HOLD: out_valid=1; out_addr/out_data/out_last SHALL remain stable while out_ready=0, with no timeout.
REQ-020 HOLD on handshake: the selected pm bit clears and out_valid<=0; if the remaining pm=0, go to IDLE with done=1 for that next cycle, else go to READ.
REQ-021 Latency: start accepted at edge T gives READ in cycle T+1 and out_valid=1 in cycle T+2; handshake at edge H gives the next out_valid at H+2.
REQ-022 Entries SHALL be emitted in ascending index order, exactly once per set mask bit; unselected registers are never emitted.
REQ-023 start while busy=1 SHALL be ignored, and mask changes during a dump SHALL have no effect.
REQ-024 done and start may coincide: start in the done cycle SHALL be accepted, since the state is IDLE.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 Changes on rf_data outside READ cycles SHALL NOT affect out_data.

Reset
REQ-027 While reset=0 at a posedge, all of the following SHALL hold the next cycle regardless of state, including mid-dump with a pending handshake:
- state=IDLE, pm=0
- out_valid=0, out_addr=0, out_data=0, out_last=0
- busy=0, done=0, rf_addr=0
REQ-028 A dump interrupted by reset SHALL NOT resume, and start asserted during reset SHALL be ignored.

Verification
REQ-029 rf holds r[i]=16'h1000+i; mask=8'b1010_0101, out_ready=1 -> entries (0,1000),(2,1002),(5,1005),(7,1007); out_last only on idx 7; done one cycle after the last handshake.
REQ-030 mask=8'h00 with start -> no out_valid; done=1 exactly one cycle later; busy stays 0.
REQ-031 mask=8'h10, out_ready held 0 for 5 cycles -> out_valid=1, out_addr=4, out_data=1004 stable for all 5 cycles; rf_data toggling meanwhile does not alter out_data.
REQ-032 mask=8'hFF, reset=0 asserted after the 3rd handshake -> next cycle out_valid=0, busy=0, out_data=0; a new start with mask=8'h80 yields the single entry (7,1007) with out_last=1.
REQ-033 start=1 with mask=8'hFF while busy -> ignored; the current dump's entry count is unchanged; start in the done cycle begins a new dump with out_valid=1 two cycles later.
